// File: rtl/subfil_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | subfil_pkg : shared types and constant helpers for the polyphase FIRs    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package subfil_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } subfil_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int clog2_min1(input int val);
    return (val <= 2) ? 1 : $clog2(val);
  endfunction

  // Drop `shift` MSBs of an aw-bit accumulator, keep ow bits, round half to even.
  function automatic logic [63:0] conv_round(input logic [63:0] acc, input int aw,
                                             input int ow, input int shift);
    int          lsb;
    logic [63:0] kept;
    logic [63:0] half;
    logic        up;
    lsb  = aw - shift - ow;
    kept = acc >> lsb;
    up   = 1'b0;
    if (lsb > 0) begin
      half = 64'd1 << (lsb - 1);
      up   = ((acc & half) != 64'd0) &&
             (((acc & (half - 64'd1)) != 64'd0) || kept[0]);
    end
    return (kept + {63'd0, up}) & ((64'd1 << ow) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/subfil_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | subfil_mac : product / accumulate / round pipeline with first/last flags |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module subfil_mac
  import subfil_pkg::*;
#(
  parameter int IW    = 16,
  parameter int CW    = 12,
  parameter int OW    = 24,
  parameter int AW    = 32,
  parameter int SHIFT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic signed [IW-1:0] i_data,
  input  logic signed [CW-1:0] i_coeff,
  output logic                 o_ce,
  output logic        [OW-1:0] o_result
);

  localparam int c_PW = IW + CW;

  logic                   r_p_valid;
  logic                   r_p_first;
  logic                   r_p_last;
  logic signed [c_PW-1:0] r_prod;
  logic                   r_a_valid;
  logic                   r_a_last;
  logic        [AW-1:0]   r_acc;
  logic        [AW-1:0]   w_prod_ext;
  logic        [OW-1:0]   w_rounded;

  assign w_prod_ext = {{(AW - c_PW){r_prod[c_PW-1]}}, r_prod};
  assign w_rounded  = OW'(conv_round(64'(r_acc), AW, OW, SHIFT));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_p_valid <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      r_prod    <= '0;
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
      r_acc     <= '0;
      o_ce      <= 1'b0;
      o_result  <= '0;
    end else begin
      r_p_valid <= i_valid;
      r_p_first <= i_first;
      r_p_last  <= i_last;
      r_prod    <= c_PW'(i_data) * c_PW'(i_coeff);
      r_a_valid <= r_p_valid;
      r_a_last  <= r_p_last;
      // First tap of a phase restarts the sum so phases never bleed together.
      if (r_p_valid)
        r_acc <= r_p_first ? w_prod_ext : r_acc + w_prod_ext;
      o_ce <= r_a_valid && r_a_last;
      if (r_a_valid && r_a_last)
        o_result <= w_rounded;
    end
  end

endmodule
`default_nettype wire

// File: rtl/subfilup.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | subfilup : polyphase 1:NUP interpolating FIR, one shared MAC per clock   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module subfilup
  import subfil_pkg::*;
#(
  parameter int    IW             = 16,
  parameter int    OW             = 24,
  parameter int    CW             = 12,
  parameter int    NUP            = 4,
  parameter int    NCOEFFS        = 64,
  parameter int    LGNCOEFFS      = $clog2(NCOEFFS),
  parameter bit    FIXED_COEFFS   = 1'b0,
  parameter string INITIAL_COEFFS = "",
  parameter int    SHIFT          = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_coeff,
  input  logic [CW-1:0] i_coeff,
  input  logic          i_ce,
  input  logic [IW-1:0] i_sample,
  output logic          o_ready,
  output logic          o_ce,
  output logic [OW-1:0] o_result,
  output logic          o_err
);

  localparam int NTAPS    = ceil_div(NCOEFFS, NUP);
  localparam int LGTAPS   = clog2_min1(NTAPS);
  localparam int AW       = IW + CW + LGTAPS;
  localparam int c_LGNUP  = clog2_min1(NUP);
  localparam int c_CIW    = LGNCOEFFS + 1;
  localparam int c_DDEPTH = 1 << LGTAPS;
  localparam int c_CDEPTH = 1 << LGNCOEFFS;
  localparam logic [LGTAPS-1:0]  c_KLAST = LGTAPS'(NTAPS - 1);
  localparam logic [c_LGNUP-1:0] c_PLAST = c_LGNUP'(NUP - 1);

  generate
    if (OW > AW - SHIFT) begin : g_param_check
      $error("subfilup: OW must not exceed AW-SHIFT");
    end
  endgenerate

  subfil_state_t      r_state;
  logic [LGTAPS-1:0]  r_wraddr;
  logic [LGTAPS-1:0]  r_start;
  logic [LGTAPS-1:0]  r_k;
  logic [c_LGNUP-1:0] r_p;
  logic [IW-1:0]      r_dmem [c_DDEPTH];
  logic [CW-1:0]      r_cmem [c_CDEPTH];

  logic               r_rd_valid;
  logic               r_rd_first;
  logic               r_rd_last;
  logic [IW-1:0]      r_rd_data;
  logic [CW-1:0]      r_rd_coeff;

  logic               w_accept;
  logic [LGTAPS-1:0]  w_daddr;
  logic [c_CIW-1:0]   w_cidx;
  logic               w_cvalid;

  assign w_accept = (r_state == ST_IDLE) && i_ce;
  assign w_daddr  = r_start - r_k;
  assign w_cidx   = c_CIW'(r_k) * c_CIW'(NUP) + c_CIW'(r_p);
  assign w_cvalid = w_cidx < c_CIW'(NCOEFFS);

  generate
    if (!FIXED_COEFFS) begin : g_coeff_wr
      logic [LGNCOEFFS-1:0] r_cwptr;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
          r_cwptr <= '0;
        else if (i_wr_coeff)
          r_cwptr <= r_cwptr + 1'b1;
      end

      always_ff @(posedge i_clk) begin
        if (i_wr_coeff)
          r_cmem[r_cwptr] <= i_coeff;
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (w_accept)
      r_dmem[r_wraddr] <= i_sample;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      o_ready  <= 1'b1;
      o_err    <= 1'b0;
      r_wraddr <= '0;
      r_start  <= '0;
      r_k      <= '0;
      r_p      <= '0;
    end else begin
      if (i_ce && !o_ready)
        o_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_ce) begin
            r_state  <= ST_RUN;
            o_ready  <= 1'b0;
            r_start  <= r_wraddr;
            r_wraddr <= r_wraddr + 1'b1;
            r_k      <= '0;
            r_p      <= '0;
          end
        end
        ST_RUN: begin
          if (r_k == c_KLAST) begin
            r_k <= '0;
            if (r_p == c_PLAST) begin
              r_state <= ST_IDLE;
              o_ready <= 1'b1;
            end else begin
              r_p <= r_p + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

  // Read stage: taps past the end of the coefficient set contribute zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_coeff <= '0;
    end else begin
      r_rd_valid <= (r_state == ST_RUN);
      r_rd_first <= (r_k == '0);
      r_rd_last  <= (r_k == c_KLAST);
      r_rd_data  <= r_dmem[w_daddr];
      r_rd_coeff <= w_cvalid ? r_cmem[w_cidx[LGNCOEFFS-1:0]] : '0;
    end
  end

  subfil_mac #(
    .IW    (IW),
    .CW    (CW),
    .OW    (OW),
    .AW    (AW),
    .SHIFT (SHIFT)
  ) u_mac (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (r_rd_valid),
    .i_first   (r_rd_first),
    .i_last    (r_rd_last),
    .i_data    (r_rd_data),
    .i_coeff   (r_rd_coeff),
    .o_ce      (o_ce),
    .o_result  (o_result)
  );

endmodule
`default_nettype wire

// File: tb/tb_subfilup.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_subfilup : scoreboard bench for subfilup, truncating and rounding     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_subfilup;

  localparam int NUP    = 4;
  localparam int NC     = 8;
  localparam int NTAPS  = 2;
  localparam int DDEPTH = 2;
  localparam int RUNLEN = NUP * NTAPS;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        wr_en  = 1'b0;
  logic [11:0] coef   = '0;
  logic        ce_in  = 1'b0;
  logic [15:0] smp    = '0;
  logic        rdy0, ce0, err0, rdy1, ce1, err1;
  logic [23:0] res0, res1;

  always #5 clk = ~clk;

  subfilup #(.IW(16), .OW(24), .CW(12), .NUP(NUP), .NCOEFFS(NC), .SHIFT(5)) u_dut_trunc (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_coeff(wr_en), .i_coeff(coef),
    .i_ce(ce_in), .i_sample(smp), .o_ready(rdy0), .o_ce(ce0), .o_result(res0), .o_err(err0)
  );

  subfilup #(.IW(16), .OW(24), .CW(12), .NUP(NUP), .NCOEFFS(NC), .SHIFT(2)) u_dut_round (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_coeff(wr_en), .i_coeff(coef),
    .i_ce(ce_in), .i_sample(smp), .o_ready(rdy1), .o_ce(ce1), .o_result(res1), .o_err(err1)
  );

  typedef struct {
    int     cyc;
    longint sum;
  } exp_t;

  exp_t        sb[$];
  int          h[NC];
  int          dm[DDEPTH];
  int          cwp      = 0;
  int          wp       = 0;
  int          last_acc = -1000;
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          exp_err  = 1'b0;
  bit          mon_en   = 1'b0;
  logic [23:0] held0    = '0;
  logic [23:0] held1    = '0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Raw 29-bit sum -> 24 output bits after dropping sh MSBs, round half to even.
  function automatic logic [23:0] exp_round(input longint s, input int sh);
    int     lsb;
    longint q, rem, half;
    lsb = 29 - sh - 24;
    if (lsb <= 0) return s[23:0];
    q    = s >>> lsb;
    rem  = s - (q <<< lsb);
    half = longint'(1) <<< (lsb - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    return q[23:0];
  endfunction

  task automatic monitor();
    bit   exp_ce;
    bit   exp_rdy;
    exp_t e;
    if (!mon_en) return;
    exp_ce = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("o_ce trunc", ce0, exp_ce);
    chk("o_ce round", ce1, exp_ce);
    if (exp_ce) begin
      e     = sb.pop_front();
      held0 = exp_round(e.sum, 5);
      held1 = exp_round(e.sum, 2);
    end
    chk("o_result trunc", res0, held0);
    chk("o_result round", res1, held1);
    exp_rdy = !(cyc > last_acc && cyc <= last_acc + RUNLEN);
    chk("o_ready trunc", rdy0, exp_rdy);
    chk("o_ready round", rdy1, exp_rdy);
    chk("o_err trunc", err0, exp_err);
    chk("o_err round", err1, exp_err);
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic model_accept(input int s);
    int     start;
    longint sum;
    exp_t   e;
    dm[wp]   = s;
    start    = wp;
    wp       = (wp + 1) % DDEPTH;
    last_acc = cyc;
    for (int p = 0; p < NUP; p++) begin
      sum = 0;
      for (int k = 0; k < NTAPS; k++)
        if (k * NUP + p < NC)
          sum += longint'(h[k * NUP + p]) * longint'(dm[(start - k + DDEPTH) % DDEPTH]);
      e.cyc = cyc + (p + 1) * NTAPS + 4;
      e.sum = sum;
      sb.push_back(e);
    end
  endtask

  task automatic send(input int s);
    bit ok;
    ok    = (cyc > last_acc + RUNLEN);
    ce_in = 1'b1;
    smp   = 16'(s);
    if (ok) model_accept(s);
    step();
    ce_in = 1'b0;
    if (!ok) exp_err = 1'b1;
  endtask

  task automatic send_next(input int s);
    while (cyc <= last_acc + RUNLEN) step();
    send(s);
  endtask

  task automatic load_coeff(input int v);
    wr_en = 1'b1;
    coef  = 12'(v);
    step();
    wr_en  = 1'b0;
    h[cwp] = v;
    cwp    = (cwp + 1) % NC;
  endtask

  task automatic impulse_run();
    send_next(0);
    send_next(0);
    send_next(1);
    send_next(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset o_ready", rdy0, 1);
    chk("reset o_ce", ce0, 0);
    chk("reset o_result", res0, 0);
    chk("reset o_err", err0, 0);
    mon_en = 1'b1;

    // Impulse with coefficients 1..8, then DC back-to-back
    for (int i = 1; i <= NC; i++) load_coeff(i);
    impulse_run();
    repeat (4) send_next(100);

    // Overrun three cycles after an acceptance
    send_next(5);
    step();
    step();
    send(7);
    send_next(9);

    // Reset asserted four cycles into a run, released two cycles later
    send_next(3);
    repeat (3) step();
    #1;
    rst_n = 1'b0;
    sb.delete();
    held0    = '0;
    held1    = '0;
    exp_err  = 1'b0;
    last_acc = -1000;
    wp       = 0;
    cwp      = 0;
    #1;
    chk("async reset o_ready", rdy0, 1);
    chk("async reset o_result", res0, 0);
    chk("async reset o_result round", res1, 0);
    chk("async reset o_err", err0, 0);
    chk("async reset o_ce", ce0, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (12) step();

    // Nine writes wrap the pointer: coefficient 0 becomes 20
    for (int i = 1; i <= NC; i++) load_coeff(i);
    load_coeff(20);
    impulse_run();

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        while (sb.size() != 0 || cyc <= last_acc + RUNLEN) step();
        for (int i = 0; i < NC; i++) load_coeff(int'($urandom_range(0, 4095)) - 2048);
      end
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 3) == 0)
        send_next(int'($urandom_range(0, 15)) - 8);
      else
        send_next(int'($urandom_range(0, 65535)) - 32768);
      if ($urandom_range(0, 9) == 0) begin
        step();
        send(int'($urandom_range(0, 65535)));
      end
    end

    repeat (20) step();
    chk("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
